// File: rtl/demistify_spi_pkg.sv
// demistify_spi_pkg: shared types and constants for the DeMiSTify SPI master.
package demistify_spi_pkg;
  typedef enum logic [1:0] {
    CS_USERIO = 2'd0,
    CS_DATAIO = 2'd1,
    CS_OSD    = 2'd2,
    CS_UPLOAD = 2'd3
  } cs_sel_t;
  typedef enum logic [2:0] {IDLE, GAP, SETUP, HIGH, LOW} spi_state_t;
  localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/demistify_spi_halfperiod_ctr.sv
// spi_halfperiod_ctr: loadable down-counter flagging the last cycle of a phase.
module spi_halfperiod_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || load_i) cnt_q <= load_val_i;
    else cnt_q <= cnt_q - W'(1);
  end
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/demistify_spi_master.sv
// demistify_spi_master: SPI mode-0 byte master with four active-low chip-selects
// and optional CS hold between bytes.
module demistify_spi_master
  import demistify_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int CLK_DIV_W = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] cs_sel,
  input  logic       cs_hold,
  input  logic       cs_release,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       SPI_SCK,
  output logic       SPI_DI,
  input  logic       SPI_DO,
  output logic       CONF_DATA0,
  output logic       SPI_SS2,
  output logic       SPI_SS3,
  output logic       SPI_SS4
);
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);
  spi_state_t state_q, state_d;
  cs_sel_t    sel_q;
  logic       hold_q, held_q, rdy_q, rxv_q, tc, accept, gap, cs_on;
  logic [7:0] tx_q, rx_q, rxd_q;
  logic [2:0] bit_q;
  logic [3:0] cs_n;
  spi_halfperiod_ctr #(.W(CLK_DIV_W)) u_ctr (
    .clk_i      (CLOCK_50),
    .rst_ni     (RESET_N),
    .load_i     (state_q == IDLE || tc),
    .load_val_i (CLK_DIV_W'(CLK_DIV - 1)),
    .tc_o       (tc)
  );
  assign tx_ready = rdy_q && state_q == IDLE;
  assign accept   = tx_valid && tx_ready;
  // A held CS must go high before a different (or released) CS is driven low.
  assign gap      = held_q && (cs_release || cs_sel != sel_q);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (gap ? GAP : SETUP) : IDLE;
      GAP:     state_d = tc ? SETUP : GAP;
      SETUP:   state_d = tc ? HIGH : SETUP;
      HIGH:    state_d = tc ? LOW : HIGH;
      LOW:     state_d = tc ? (bit_q == LAST_BIT ? IDLE : HIGH) : LOW;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      sel_q   <= CS_USERIO;
      hold_q  <= 1'b0;
      held_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rxv_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      rxv_q   <= 1'b0;
      if (state_q == IDLE && cs_release) held_q <= 1'b0;
      if (accept) begin
        tx_q   <= tx_data;
        sel_q  <= cs_sel_t'(cs_sel);
        hold_q <= cs_hold;
        held_q <= 1'b0;
        bit_q  <= '0;
      end
      if (state_d == HIGH && state_q != HIGH) rx_q <= {rx_q[6:0], SPI_DO};
      if (state_q == HIGH && tc && bit_q != LAST_BIT) tx_q <= {tx_q[6:0], 1'b0};
      if (state_q == LOW && tc) begin
        if (bit_q == LAST_BIT) begin
          rxv_q  <= 1'b1;
          rxd_q  <= rx_q;
          held_q <= hold_q;
        end else bit_q <= bit_q + 3'd1;
      end
    end
  end
  assign cs_on      = state_q inside {SETUP, HIGH, LOW} || (state_q == IDLE && held_q);
  assign cs_n       = cs_on ? ~(4'b0001 << sel_q) : 4'hF;
  assign CONF_DATA0 = cs_n[0];
  assign SPI_SS2    = cs_n[1];
  assign SPI_SS3    = cs_n[2];
  assign SPI_SS4    = cs_n[3];
  assign SPI_SCK    = state_q == HIGH;
  assign SPI_DI     = tx_q[7];
  assign rx_valid   = rxv_q;
  assign rx_data    = rxd_q;
endmodule

// File: tb/tb_demistify_spi_master.sv
// tb_demistify_spi_master: directed checks of the SPI master at CLK_DIV=4 (with a
// loopback slave) and CLK_DIV=1 (MISO tied high).
module tb_demistify_spi_master;
  logic clk = 1'b0, rst_n, tv4, tv1, cs_hold, cs_rel;
  logic [7:0] tx_data;
  logic [1:0] cs_sel;
  logic rdy4, rxv4, sck4, di4, rdy1, rxv1, sck1, di1;
  logic [7:0] rxd4, rxd1, slv, mosi_rec;
  logic [3:0] cs4, cs1;
  logic bitcap = 1'b0, sck_p = 1'b0, d2;
  logic [15:0] pat;
  int total = 0, bad = 0, viol = 0, pulses = 0, cyc = 0, cs_lo, oth, allhi, rc, n, lo;

  always #10 clk = ~clk;

  demistify_spi_master #(.CLK_DIV(4), .CLK_DIV_W(8)) u4 (
    .CLOCK_50(clk), .RESET_N(rst_n), .tx_valid(tv4), .tx_ready(rdy4), .tx_data(tx_data),
    .cs_sel(cs_sel), .cs_hold(cs_hold), .cs_release(cs_rel), .rx_valid(rxv4), .rx_data(rxd4),
    .SPI_SCK(sck4), .SPI_DI(di4), .SPI_DO(slv[7]), .CONF_DATA0(cs4[0]), .SPI_SS2(cs4[1]),
    .SPI_SS3(cs4[2]), .SPI_SS4(cs4[3]));

  demistify_spi_master #(.CLK_DIV(1), .CLK_DIV_W(8)) u1 (
    .CLOCK_50(clk), .RESET_N(rst_n), .tx_valid(tv1), .tx_ready(rdy1), .tx_data(tx_data),
    .cs_sel(cs_sel), .cs_hold(cs_hold), .cs_release(cs_rel), .rx_valid(rxv1), .rx_data(rxd1),
    .SPI_SCK(sck1), .SPI_DI(di1), .SPI_DO(1'b1), .CONF_DATA0(cs1[0]), .SPI_SS2(cs1[1]),
    .SPI_SS3(cs1[2]), .SPI_SS4(cs1[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample at negedge, drop one-cycle inputs, run the mode-0 loopback slave.
  task automatic tick();
    @(negedge clk);
    cyc++;
    tv4 = 1'b0;
    tv1 = 1'b0;
    cs_rel = 1'b0;
    if (!sck_p && sck4) begin
      mosi_rec = {mosi_rec[6:0], di4};
      bitcap = di4;
      pulses++;
    end
    if (sck_p && !sck4) slv = {slv[6:0], bitcap};
    sck_p = sck4;
    if ($countones(~cs4) > 1 || (sck4 && &cs4) || $countones(~cs1) > 1 || (sck1 && &cs1)) viol++;
  endtask

  task automatic start4(input logic [7:0] d, input logic [1:0] s, input logic h, input logic r);
    tv4 = 1'b1;
    tx_data = d;
    cs_sel = s;
    cs_hold = h;
    cs_rel = r;
  endtask

  task automatic run4(input logic [1:0] s, output int rcyc);
    cyc = 0; cs_lo = 0; oth = 0; allhi = 0; rcyc = -1;
    while (rcyc < 0 && cyc < 300) begin
      tick();
      if (rxv4) rcyc = cyc;
      else begin
        if (!cs4[s]) cs_lo++;
        if ((~cs4 & ~(4'b0001 << s)) != 4'h0) oth++;
        if (&cs4) allhi++;
      end
    end
    chk("rx_seen", rxv4, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; tv4 = 1'b0; tv1 = 1'b0; cs_hold = 1'b0; cs_rel = 1'b0;
    tx_data = 8'h00; cs_sel = 2'd0; slv = 8'h00; mosi_rec = 8'h00;
    repeat (3) tick();
    chk("rst_ready", rdy4, 1'b0);
    chk("rst_cs", cs4, 4'hF);
    chk("rst_sck_di", {sck4, di4}, 2'b00);
    chk("rst_rx", {rxv4, rxd4}, 9'h000);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {rdy4, rdy1}, 2'b11);

    // single byte, CONF_DATA0, no hold
    slv = 8'h3C; pulses = 0;
    start4(8'hA5, 2'd0, 1'b0, 1'b0);
    run4(2'd0, rc);
    chk("t1_latency", rc, 69);
    chk("t1_rx", rxd4, 8'h3C);
    chk("t1_mosi", mosi_rec, 8'hA5);
    chk("t1_cs_low", cs_lo, 68);
    chk("t1_other_cs", oth, 0);
    chk("t1_cs_end", cs4, 4'hF);
    chk("t1_pulses", pulses, 8);
    chk("t1_ready", rdy4, 1'b1);
    tick();
    chk("t1_rxv_pulse", rxv4, 1'b0);

    // back-to-back on held SPI_SS2; loopback slave now holds A5
    pulses = 0;
    start4(8'h01, 2'd1, 1'b1, 1'b0);
    run4(2'd1, rc);
    chk("t2a_latency", rc, 69);
    chk("t2a_rx", rxd4, 8'hA5);
    chk("t2a_cs_held", cs4, 4'hD);
    chk("t2a_cs_low", cs_lo, 68);
    start4(8'hFF, 2'd1, 1'b0, 1'b0);
    run4(2'd1, rc);
    chk("t2b_latency", rc, 69);
    chk("t2b_cs_low", cs_lo, 68);
    chk("t2b_no_gap", allhi, 0);
    chk("t2b_rx", rxd4, 8'h01);
    chk("t2b_pulses", pulses, 16);
    chk("t2b_cs_end", cs4, 4'hF);

    // held SPI_SS2 then SPI_SS3: gap of CLK_DIV cycles
    start4(8'h5A, 2'd1, 1'b1, 1'b0);
    run4(2'd1, rc);
    chk("t3a_rx", rxd4, 8'hFF);
    chk("t3a_cs_held", cs4, 4'hD);
    start4(8'hC3, 2'd2, 1'b0, 1'b0);
    run4(2'd2, rc);
    chk("t3b_latency", rc, 73);
    chk("t3b_gap", allhi, 4);
    chk("t3b_cs_low", cs_lo, 68);
    chk("t3b_other_cs", oth, 0);
    chk("t3b_rx", rxd4, 8'h5A);
    chk("t3b_cs_end", cs4, 4'hF);

    // reset during the 4th HIGH phase
    start4(8'h0F, 2'd0, 1'b0, 1'b0);
    cyc = 0;
    repeat (30) tick();
    chk("t4_mid_sck", sck4, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("t4_rst_sck", sck4, 1'b0);
    chk("t4_rst_cs", cs4, 4'hF);
    chk("t4_rst_flags", {rxv4, rdy4}, 2'b00);
    chk("t4_rst_rxdata", rxd4, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_ready", rdy4, 1'b1);
    n = 0;
    repeat (80) begin
      tick();
      if (rxv4) n++;
    end
    chk("t4_no_rxv", n, 0);

    // CLK_DIV=1 on SPI_SS4 with MISO high
    tx_data = 8'h80; cs_sel = 2'd3; cs_hold = 1'b0; tv1 = 1'b1;
    cyc = 0; pat = 16'h0; lo = 0; rc = -1; d2 = 1'b0;
    while (rc < 0 && cyc < 50) begin
      tick();
      if (rxv1) rc = cyc;
      else begin
        if (!cs1[3]) lo++;
        if (cyc >= 2 && cyc <= 17) pat = {pat[14:0], sck1};
        if (cyc == 2) d2 = di1;
      end
    end
    chk("t5_latency", rc, 18);
    chk("t5_rx", rxd1, 8'hFF);
    chk("t5_sck_toggle", pat, 16'hAAAA);
    chk("t5_ss4_low", lo, 17);
    chk("t5_first_bit", d2, 1'b1);
    chk("t5_cs_end", cs1, 4'hF);

    // release together with a new request on the held CS
    slv = 8'h96;
    start4(8'h33, 2'd0, 1'b1, 1'b0);
    run4(2'd0, rc);
    chk("t6a_rx", rxd4, 8'h96);
    chk("t6a_cs_held", cs4, 4'hE);
    start4(8'h44, 2'd0, 1'b0, 1'b1);
    run4(2'd0, rc);
    chk("t6b_cs_high_gap", allhi >= 1, 1'b1);
    chk("t6b_latency", rc, 69 + allhi);
    chk("t6b_rx", rxd4, 8'h33);
    chk("t6b_cs_end", cs4, 4'hF);

    // plain release of a held CS
    start4(8'h12, 2'd3, 1'b1, 1'b0);
    run4(2'd3, rc);
    chk("t7_cs_held", cs4, 4'h7);
    tick();
    tick();
    chk("t7_still_held", cs4, 4'h7);
    cs_rel = 1'b1;
    tick();
    chk("t7_released", cs4, 4'hF);

    chk("cs_invariant", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
